// File: rtl/fmc_i2c_init_seq_pkg.sv
// Shared types and the board bring-up command table for the FMC I2C init sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fmc_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    GAP,
    DONE,
    FAIL
  } state_t;

  // One register write: 7-bit target address, register byte, data byte.
  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] reg_byte;
    logic [7:0] data;
  } cmd_entry_t;

  localparam int CMD_TABLE_LEN = 4;

  // Entry 0 lights LED4 on the CPLD so bring-up progress is visible on the board.
  // Entry 1 steers the I2C mux to the FMC branch, entry 2 enables all CPLD
  // outputs, entry 3 programs the clock synthesizer control register.
  localparam cmd_entry_t CMD_TABLE [CMD_TABLE_LEN] = '{
    '{addr: 7'h3E, reg_byte: 8'h02, data: 8'h01},
    '{addr: 7'h74, reg_byte: 8'h00, data: 8'h08},
    '{addr: 7'h3E, reg_byte: 8'h03, data: 8'hFF},
    '{addr: 7'h68, reg_byte: 8'h10, data: 8'hA5}
  };

endpackage

// File: rtl/fmc_i2c_init_seq_if.sv
// Request/response handshake between the init sequencer and the I2C byte engine.
// Latency: n/a (wires only).
// Backpressure: cmd_valid holds until cmd_ready; rsp_valid is a one-cycle pulse.
interface fmc_i2c_init_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_nack;

  modport master (
    output cmd_valid, cmd_addr, cmd_reg, cmd_data,
    input  cmd_ready, rsp_valid, rsp_nack
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_reg, cmd_data,
    output cmd_ready, rsp_valid, rsp_nack
  );
endinterface

// File: rtl/fmc_i2c_init_seq_cmd_rom.sv
// Command-table lookup: maps an entry index to its register write.
// Latency: combinational.
// Backpressure: none; indices past the table return an all-zero entry.
import fmc_i2c_pkg::*;

module fmc_i2c_cmd_rom (
  input  logic [2:0] idx,
  output cmd_entry_t entry
);
  localparam int AW = $clog2(CMD_TABLE_LEN);

  // Table read with a safe zero for out-of-range indices.
  always_comb begin
    entry = '0;
    if (int'(idx) < CMD_TABLE_LEN) entry = CMD_TABLE[idx[AW-1:0]];
  end
endmodule

// File: rtl/fmc_i2c_init_seq.sv
// Walks the command table issuing I2C writes, retrying NACKs/timeouts after an idle gap.
// Latency: first request one cycle after start; done/error one cycle after the last response.
// Backpressure: request held stable until cmd_ready; the response timeout runs only after acceptance.
import fmc_i2c_pkg::*;

module fmc_i2c_init_seq #(
  parameter int N_CMDS      = 4,
  parameter int MAX_RETRY   = 3,
  parameter int RSP_TIMEOUT = 65535,
  parameter int GAP_CYC     = 1000
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [2:0]          err_idx,
  fmc_i2c_init_seq_if.master  bus
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = (RSP_TIMEOUT > 0) ? $clog2(RSP_TIMEOUT + 1) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [2:0]    LAST_IDX  = 3'(N_CMDS - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TO_LIM    = TW'(RSP_TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] to_q, to_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          err_q, err_d;
  logic [2:0]    err_idx_q, err_idx_d;
  cmd_entry_t    rom_entry;

  logic       cmd_vld_q;
  logic [6:0] cmd_addr_q;
  logic [7:0] cmd_reg_q;
  logic [7:0] cmd_data_q;

  // Looked up with the next index so the request fields can be registered on ISSUE entry.
  fmc_i2c_cmd_rom u_rom (
    .idx   (idx_d),
    .entry (rom_entry)
  );

  // Next-state, counter and error-flag logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    to_d      = to_q;
    gap_d     = gap_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d     = 1'b0;
          err_idx_d = 3'd0;
          idx_d     = 3'd0;
          retry_d   = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.cmd_ready) begin
          to_d    = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A response in the expiry cycle wins over the timeout.
        if (bus.rsp_valid && !bus.rsp_nack) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            retry_d = '0;
            state_d = ISSUE;
          end
        end else if (bus.rsp_valid || (to_q == TO_LIM)) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            gap_d   = '0;
            state_d = GAP;
          end else begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
            state_d   = FAIL;
          end
        end else if (to_q != TO_LIM) begin
          to_d = to_q + TW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = ISSUE;
        else                   gap_d   = gap_q + GW'(1);
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and sticky error flag.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      retry_q   <= '0;
      to_q      <= '0;
      gap_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      to_q      <= to_d;
      gap_q     <= gap_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  // Registered request: valid exactly while in ISSUE, fields frozen for its duration.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cmd_vld_q  <= 1'b0;
      cmd_addr_q <= 7'd0;
      cmd_reg_q  <= 8'd0;
      cmd_data_q <= 8'd0;
    end else if (state_d == ISSUE) begin
      cmd_vld_q  <= 1'b1;
      cmd_addr_q <= rom_entry.addr;
      cmd_reg_q  <= rom_entry.reg_byte;
      cmd_data_q <= rom_entry.data;
    end else begin
      cmd_vld_q  <= 1'b0;
    end
  end

  assign bus.cmd_valid = cmd_vld_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign bus.cmd_reg   = cmd_reg_q;
  assign bus.cmd_data  = cmd_data_q;

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign error   = err_q;
  assign err_idx = err_idx_q;

endmodule

// File: tb/tb_fmc_i2c_init_seq.sv
// Directed bench for the FMC I2C init sequencer acting as the byte engine.
// Latency: n/a.
// Backpressure: stalls cmd_ready on request to exercise the hold behaviour.
module tb_fmc_i2c_init_seq;

  logic       CLK;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] err_idx;

  fmc_i2c_init_seq_if bus ();

  fmc_i2c_init_seq #(
    .N_CMDS      (4),
    .MAX_RETRY   (3),
    .RSP_TIMEOUT (100),
    .GAP_CYC     (1000)
  ) dut (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .err_idx (err_idx),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp    = 0;
  int n_mis    = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;

  // Expected table, written out by hand: {addr, reg, data}.
  logic [22:0] exp_tab [4] = '{
    {7'h3E, 8'h02, 8'h01},
    {7'h74, 8'h00, 8'h08},
    {7'h3E, 8'h03, 8'hFF},
    {7'h68, 8'h10, 8'hA5}
  };

  // Counts every cycle done is high.
  always @(posedge CLK) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // One request/response exchange, called and returning on a falling edge.
  task automatic txn(input string tag, input int i, input int rdy_dly, input int rsp_dly,
                     input bit nack, input bit respond, output int wcyc);
    logic [22:0] e;
    bit stable;
    e = exp_tab[i];
    wcyc = 0;
    while (bus.cmd_valid !== 1'b1 && wcyc < 5000) begin
      @(negedge CLK);
      wcyc++;
    end
    chk({tag, " req_seen"}, 32'(bus.cmd_valid), 32'd1);
    chk({tag, " entry"}, 32'({bus.cmd_addr, bus.cmd_reg, bus.cmd_data}), 32'(e));
    stable = 1'b1;
    repeat (rdy_dly) begin
      @(negedge CLK);
      if (bus.cmd_valid !== 1'b1 || {bus.cmd_addr, bus.cmd_reg, bus.cmd_data} !== e) stable = 1'b0;
    end
    if (rdy_dly > 0) chk({tag, " held_stable"}, 32'(stable), 32'd1);
    bus.cmd_ready = 1'b1;
    @(negedge CLK);
    bus.cmd_ready = 1'b0;
    acc_cnt++;
    chk({tag, " valid_drop"}, 32'(bus.cmd_valid), 32'd0);
    if (respond) begin
      repeat (rsp_dly - 1) @(negedge CLK);
      bus.rsp_valid = 1'b1;
      bus.rsp_nack  = nack;
      @(negedge CLK);
      bus.rsp_valid = 1'b0;
      bus.rsp_nack  = 1'b0;
    end
  endtask

  initial begin
    int w;
    int acc0;
    int done0;
    bit seen;

    rst_n         = 1'b0;
    start         = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_nack  = 1'b0;

    // Reset state.
    #1;
    chk("reset outputs", 32'({busy, done, error, err_idx, bus.cmd_valid}), 32'd0);
    chk("reset cmd fields", 32'({bus.cmd_addr, bus.cmd_reg, bus.cmd_data}), 32'd0);
    repeat (3) @(negedge CLK);
    rst_n = 1'b1;
    repeat (2) @(negedge CLK);
    // A response outside WAIT_RSP must not start anything.
    bus.rsp_valid = 1'b1;
    @(negedge CLK);
    bus.rsp_valid = 1'b0;
    @(negedge CLK);
    chk("stray rsp idle", 32'({busy, bus.cmd_valid}), 32'd0);

    // All entries ACKed after 10 cycles.
    acc0 = acc_cnt; done0 = done_cnt;
    pulse_start();
    chk("t1 busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) txn($sformatf("t1 e%0d", i), i, 0, 10, 1'b0, 1'b1, w);
    repeat (3) @(negedge CLK);
    chk("t1 done once", 32'(done_cnt - done0), 32'd1);
    chk("t1 accepts", 32'(acc_cnt - acc0), 32'd4);
    chk("t1 end flags", 32'({busy, error}), 32'd0);

    // Entry 1 NACKed twice, then ACKed.
    acc0 = acc_cnt; done0 = done_cnt;
    pulse_start();
    txn("t2 e0", 0, 0, 10, 1'b0, 1'b1, w);
    txn("t2 e1a", 1, 0, 10, 1'b1, 1'b1, w);
    txn("t2 e1b", 1, 0, 10, 1'b1, 1'b1, w);
    chk("t2 gap1", 32'(w >= 1000), 32'd1);
    txn("t2 e1c", 1, 0, 10, 1'b0, 1'b1, w);
    chk("t2 gap2", 32'(w >= 1000), 32'd1);
    txn("t2 e2", 2, 0, 10, 1'b0, 1'b1, w);
    txn("t2 e3", 3, 0, 10, 1'b0, 1'b1, w);
    repeat (3) @(negedge CLK);
    chk("t2 done once", 32'(done_cnt - done0), 32'd1);
    chk("t2 accepts", 32'(acc_cnt - acc0), 32'd6);
    chk("t2 error", 32'(error), 32'd0);

    // Entry 2 NACKed four times: retries exhausted.
    acc0 = acc_cnt; done0 = done_cnt;
    pulse_start();
    txn("t3 e0", 0, 0, 10, 1'b0, 1'b1, w);
    txn("t3 e1", 1, 0, 10, 1'b0, 1'b1, w);
    for (int k = 0; k < 4; k++) txn($sformatf("t3 e2 try%0d", k), 2, 0, 10, 1'b1, 1'b1, w);
    repeat (2) @(negedge CLK);
    chk("t3 error", 32'(error), 32'd1);
    chk("t3 err_idx", 32'(err_idx), 32'd2);
    chk("t3 busy", 32'(busy), 32'd0);
    chk("t3 no done", 32'(done_cnt - done0), 32'd0);
    seen = 1'b0;
    repeat (1200) begin
      @(negedge CLK);
      if (bus.cmd_valid === 1'b1) seen = 1'b1;
    end
    chk("t3 entry3 never", 32'(seen), 32'd0);
    chk("t3 accepts", 32'(acc_cnt - acc0), 32'd6);
    chk("t3 error sticky", 32'(error), 32'd1);

    // No response ever: timeout, three retries, then failure on entry 0.
    acc0 = acc_cnt; done0 = done_cnt;
    pulse_start();
    chk("t4 error cleared", 32'(error), 32'd0);
    txn("t4 try0", 0, 0, 0, 1'b0, 1'b0, w);
    for (int k = 1; k < 4; k++) begin
      txn($sformatf("t4 try%0d", k), 0, 0, 0, 1'b0, 1'b0, w);
      chk($sformatf("t4 timeout+gap %0d", k), 32'(w >= 1100 && w <= 1102), 32'd1);
    end
    w = 0;
    while (error !== 1'b1 && w < 400) begin
      @(negedge CLK);
      w++;
    end
    chk("t4 error", 32'(error), 32'd1);
    chk("t4 err_idx", 32'(err_idx), 32'd0);
    repeat (2) @(negedge CLK);
    chk("t4 busy", 32'(busy), 32'd0);
    chk("t4 no done", 32'(done_cnt - done0), 32'd0);
    chk("t4 accepts", 32'(acc_cnt - acc0), 32'd4);

    // cmd_ready stalled for 50 cycles; response 90 cycles after acceptance still in time.
    acc0 = acc_cnt; done0 = done_cnt;
    pulse_start();
    txn("t5 e0", 0, 50, 90, 1'b0, 1'b1, w);
    txn("t5 e1", 1, 0, 10, 1'b0, 1'b1, w);
    chk("t5 no gap after ack", 32'(w), 32'd0);
    txn("t5 e2", 2, 0, 10, 1'b0, 1'b1, w);
    txn("t5 e3", 3, 0, 10, 1'b0, 1'b1, w);
    repeat (3) @(negedge CLK);
    chk("t5 done once", 32'(done_cnt - done0), 32'd1);
    chk("t5 error", 32'(error), 32'd0);

    // Reset pulsed while waiting for a response.
    done0 = done_cnt;
    pulse_start();
    txn("t6 e0", 0, 0, 10, 1'b0, 1'b1, w);
    txn("t6 e1", 1, 0, 0, 1'b0, 1'b0, w);
    repeat (3) @(negedge CLK);
    chk("t6 busy before rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6 rst outputs", 32'({busy, done, error, err_idx, bus.cmd_valid}), 32'd0);
    chk("t6 rst cmd fields", 32'({bus.cmd_addr, bus.cmd_reg, bus.cmd_data}), 32'd0);
    @(negedge CLK);
    rst_n = 1'b1;
    repeat (5) @(negedge CLK);
    chk("t6 after rst", 32'({busy, error, bus.cmd_valid}), 32'd0);
    chk("t6 no done", 32'(done_cnt - done0), 32'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) txn($sformatf("t6 rerun e%0d", i), i, 0, 10, 1'b0, 1'b1, w);
    repeat (3) @(negedge CLK);
    chk("t6 rerun done", 32'(done_cnt - done0), 32'd1);
    chk("t6 rerun flags", 32'({busy, error}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fmc_i2c_init_seq.md
FMC_I2C_INIT_SEQ -- requirements
Module: fmc_i2c_init_seq

Interface
REQ-001 SHALL have parameter N_CMDS, default 4: number of command-table entries executed per run.
REQ-002 SHALL have parameter MAX_RETRY, default 3: extra attempts per entry after a NACK or timeout.
REQ-003 SHALL have parameter RSP_TIMEOUT, default 65535: clock cycles allowed in WAIT_RSP before the attempt counts as failed.
REQ-004 SHALL have parameter GAP_CYC, default 1000: idle cycles inserted before each retry.
REQ-005 SHALL have port CLK, input, 1: single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: one-cycle pulse that begins a sequence run; ignored unless the FSM is in IDLE.
REQ-008 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when all entries were ACKed.
REQ-010 SHALL have port error, output, 1: sticky failure flag, cleared by the next accepted start.
REQ-011 SHALL have port err_idx, output, 3: index of the failing entry, valid while error is high.
REQ-012 SHALL have port cmd_valid, output, 1: a write request to the byte engine is pending.
REQ-013 SHALL have port cmd_ready, input, 1: the byte engine accepts the request.
REQ-014 SHALL have port cmd_addr, output, 7: 7-bit target address.
REQ-015 SHALL have port cmd_reg, output, 8: register byte.
REQ-016 SHALL have port cmd_data, output, 8: data byte.
REQ-017 SHALL have port rsp_valid, input, 1: one-cycle pulse marking the end of a transaction.
REQ-018 SHALL have port rsp_nack, input, 1: NACK flag, sampled only when rsp_valid is high.

Function
REQ-019 SHALL implement the FSM states IDLE, ISSUE, WAIT_RSP, GAP, DONE and FAIL.
REQ-020 IDLE: an accepted start SHALL clear error and set idx=0 and retry=0; the FSM moves to ISSUE on the next cycle.
REQ-021 ISSUE: cmd_valid=1, with cmd_addr, cmd_reg and cmd_data taken from table[idx]; these outputs SHALL be registered and stable while cmd_valid=1.
REQ-022 A request is accepted on the cycle where cmd_valid and cmd_ready are both high; cmd_valid SHALL drop on the following cycle and the FSM SHALL move to WAIT_RSP with the timeout counter reset to 0.
REQ-023 WAIT_RSP, on rsp_valid with rsp_nack=0: if idx==N_CMDS-1 the FSM SHALL go to DONE, else it SHALL increment idx, clear retry and go to ISSUE.
REQ-024 WAIT_RSP, on rsp_valid with rsp_nack=1, or when the timeout counter reaches RSP_TIMEOUT: if retry<MAX_RETRY the FSM SHALL increment retry and go to GAP, else it SHALL go to FAIL.
REQ-025 If rsp_valid arrives on the same cycle the timeout expires, rsp_valid SHALL take priority.
REQ-026 GAP: the FSM SHALL count GAP_CYC cycles, then return to ISSUE with the same idx.
REQ-027 DONE: done=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-028 FAIL: error=1 and err_idx=idx, then the FSM SHALL return to IDLE on the next cycle; error stays set.
REQ-029 rsp_valid arriving outside WAIT_RSP SHALL be ignored.
REQ-030 start pulses while busy=1 SHALL be ignored.
REQ-031 The retry counter SHALL be sized for MAX_RETRY+1 values without wrap.
REQ-032 The timeout counter SHALL saturate and SHALL NOT wrap.

Reset
REQ-033 While rst_n=0, the block SHALL hold: state=IDLE, idx=0, retry=0, all counters 0, busy=0, done=0, error=0, err_idx=0, cmd_valid=0, cmd_addr=0, cmd_reg=0, cmd_data=0.
REQ-034 An rst_n assertion during a run SHALL abort the run immediately, with no done and no error produced.

Structure
REQ-035 The package fmc_i2c_pkg SHALL hold the state enum, the command-entry struct {addr[6:0], reg[7:0], data[7:0]}, and the constant table.
REQ-036 The constant table SHALL contain: entry 0 = CPLD 7'h3E, reg 8'h02, data 8'h01 (LED4 on); entries 1-3 = board-bring-up writes owned by the package.
REQ-037 The table lookup SHALL be implemented as the sub-module fmc_i2c_cmd_rom (idx in, entry out, combinational).

Verification
REQ-038 The bench SHALL cover: start, with all responses ACKed after 10 cycles -> 4 accepted requests, entry 0 = 3E/02/01, done pulse once, error=0.
REQ-039 The bench SHALL cover: entry 1 NACKed twice, then ACKed -> 3 requests for idx 1, each retry preceded by ≥1000 idle cycles, done=1.
REQ-040 The bench SHALL cover: entry 2 NACKed 4 times -> error=1, err_idx=2, no done, busy=0, and entry 3 never issued.
REQ-041 The bench SHALL cover: no rsp_valid after the first request, with RSP_TIMEOUT=100 -> 3 retries, then error=1, err_idx=0.
REQ-042 The bench SHALL cover: cmd_ready held low for 50 cycles -> cmd_valid and its data held stable, and the timeout counter not running.
REQ-043 The bench SHALL cover: rst_n pulsed low while in WAIT_RSP -> all outputs 0 immediately; a new start then re-runs from entry 0.
